mul4_stream_acc: RTL and testbench

MUL4_STREAM_ACC -- requirements
Module: mul4_stream_acc

---
 rtl/mul4_stream_acc.sv | 188 ++++++++++++++++++
 tb/tb_mul4_stream_acc.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul4_stream_acc.sv
// mul4_stream_acc: streaming multiply-accumulate. Accepts COUNT pairs of 4-bit unsigned
// operands over a valid/ready handshake, multiplies each pair with a combinational array
// multiplier and presents the 12-bit sum of the COUNT products on a held valid/ready output.
// The multiplier lives in this file as a helper so the block stays self-contained.

// mul4_array: 4x4 unsigned array multiplier built from rows of ripple full adders.
module mul4_array (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    // Each row adds one partial product into the running upper bits; the row's LSB retires
    // as a finished product bit and the rest shifts down into the next row.
    always_comb begin
        logic [4:0] run;
        logic [4:0] row;
        logic       carry;
        logic       x;
        logic       y;
        run   = {1'b0, a & {4{b[0]}}};
        row   = '0;
        carry = 1'b0;
        x     = 1'b0;
        y     = 1'b0;
        p     = '0;
        p[0]  = run[0];
        for (int i = 1; i < 4; i++) begin
            carry = 1'b0;
            row   = '0;
            for (int j = 0; j < 4; j++) begin
                x      = run[j+1];
                y      = a[j] & b[i];
                row[j] = x ^ y ^ carry;
                carry  = (x & y) | (x & carry) | (y & carry);
            end
            row[4] = carry;
            run    = row;
            p[i]   = run[0];
        end
        p[7:4] = run[4:1];
    end

endmodule

module mul4_stream_acc #(
    parameter int unsigned COUNT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  A,
    input  logic [3:0]  B,
    output logic [11:0] SUM,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [0:0] {StAcc, StDone} state_e;

    // Counts run 0..16, so five bits cover every legal COUNT.
    localparam logic [4:0] CountVal = 5'(COUNT);

    state_e      state_q, state_d;
    logic [3:0]  op_a_q, op_a_d;
    logic [3:0]  op_b_q, op_b_d;
    logic        s1_valid_q, s1_valid_d;
    logic [4:0]  acc_cnt_q, acc_cnt_d;
    logic [4:0]  prod_cnt_q, prod_cnt_d;
    logic [11:0] acc_q, acc_d;
    logic [11:0] sum_q, sum_d;
    logic        out_valid_q, out_valid_d;

    logic [7:0]  prod;
    logic [11:0] acc_sum;
    logic        xfer;
    logic        last_prod;
    logic        drain;

    mul4_array u_mul (
        .a(op_a_q),
        .b(op_b_q),
        .p(prod)
    );

    // Shared event decode used by both the FSM and the datapath.
    always_comb begin
        acc_sum   = acc_q + {4'b0000, prod};
        xfer      = in_valid && in_ready;
        last_prod = s1_valid_q && ((prod_cnt_q + 5'd1) == CountVal);
        drain     = out_valid_q && out_ready;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StAcc;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: collect until the last product lands, hold until drained.
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = StAcc;
        end else begin
            unique case (state_q)
                StAcc:  if (last_prod) state_d = StDone;
                StDone: if (drain) state_d = StAcc;
            endcase
        end
    end

    // FSM outputs; in_ready is forced low while reset is held.
    always_comb begin
        in_ready  = rst_n && (state_q == StAcc) && (acc_cnt_q < CountVal) && !clr;
        out_valid = out_valid_q;
        SUM       = sum_q;
    end

    // Datapath next state: operand capture, accumulate, result load and drain.
    always_comb begin
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        s1_valid_d  = 1'b0;
        acc_cnt_d   = acc_cnt_q;
        prod_cnt_d  = prod_cnt_q;
        acc_d       = acc_q;
        sum_d       = sum_q;
        out_valid_d = out_valid_q;
        if (clr) begin
            // Abort wins over everything; the last published SUM is kept.
            acc_cnt_d   = '0;
            prod_cnt_d  = '0;
            acc_d       = '0;
            out_valid_d = 1'b0;
        end else begin
            if (xfer) begin
                op_a_d     = A;
                op_b_d     = B;
                acc_cnt_d  = acc_cnt_q + 5'd1;
                s1_valid_d = 1'b1;
            end
            if (s1_valid_q) begin
                acc_d      = acc_sum;
                prod_cnt_d = prod_cnt_q + 5'd1;
                if (last_prod) begin
                    sum_d       = acc_sum;
                    out_valid_d = 1'b1;
                end
            end
            if (drain) begin
                acc_cnt_d   = '0;
                prod_cnt_d  = '0;
                acc_d       = '0;
                out_valid_d = 1'b0;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_q      <= '0;
            op_b_q      <= '0;
            s1_valid_q  <= 1'b0;
            acc_cnt_q   <= '0;
            prod_cnt_q  <= '0;
            acc_q       <= '0;
            sum_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            s1_valid_q  <= s1_valid_d;
            acc_cnt_q   <= acc_cnt_d;
            prod_cnt_q  <= prod_cnt_d;
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_mul4_stream_acc.sv
// Bench for mul4_stream_acc: three instances (COUNT = 4, 16, 1) driven one at a time.
// A transaction-level model predicts in_ready, out_valid and SUM every cycle; table
// vectors and hand sequences add targeted checks on top.
module tb_mul4_stream_acc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  clr_v;
    logic [2:0]  iv_v;
    logic [2:0]  ordy_v;
    logic [3:0]  a_v [3];
    logic [3:0]  b_v [3];
    logic        ir0, ir1, ir2;
    logic        ov0, ov1, ov2;
    logic [11:0] s0, s1, s2;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state per instance.
    int m_cnt [3];
    int m_part[3];
    int m_res [3];
    int m_sum [3];
    bit m_pend[3];
    bit m_ov  [3];
    int dut_acc[3];

    logic        obs_ov;
    logic        obs_ir;
    logic [11:0] obs_sum;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        int          sum;
    } vec_t;
    vec_t tbl[6];

    always #5 clk = ~clk;

    mul4_stream_acc #(.COUNT(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .clr(clr_v[0]), .in_valid(iv_v[0]), .in_ready(ir0),
        .A(a_v[0]), .B(b_v[0]), .SUM(s0), .out_valid(ov0), .out_ready(ordy_v[0])
    );
    mul4_stream_acc #(.COUNT(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .clr(clr_v[1]), .in_valid(iv_v[1]), .in_ready(ir1),
        .A(a_v[1]), .B(b_v[1]), .SUM(s1), .out_valid(ov1), .out_ready(ordy_v[1])
    );
    mul4_stream_acc #(.COUNT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr_v[2]), .in_valid(iv_v[2]), .in_ready(ir2),
        .A(a_v[2]), .B(b_v[2]), .SUM(s2), .out_valid(ov2), .out_ready(ordy_v[2])
    );

    function automatic int cnt_of(int idx);
        case (idx)
            0:       return 4;
            1:       return 16;
            default: return 1;
        endcase
    endfunction

    function automatic logic get_ir(int idx);
        case (idx)
            0:       return ir0;
            1:       return ir1;
            default: return ir2;
        endcase
    endfunction

    function automatic logic get_ov(int idx);
        case (idx)
            0:       return ov0;
            1:       return ov1;
            default: return ov2;
        endcase
    endfunction

    function automatic logic [11:0] get_sum(int idx);
        case (idx)
            0:       return s0;
            1:       return s1;
            default: return s2;
        endcase
    endfunction

    task automatic chk(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i]  = 0;
            m_part[i] = 0;
            m_res[i]  = 0;
            m_sum[i]  = 0;
            m_pend[i] = 1'b0;
            m_ov[i]   = 1'b0;
        end
    endtask

    // One clock of stimulus on instance idx; all other instances are idle.
    task automatic step(int idx, bit iv, logic [3:0] a, logic [3:0] b, bit ordy, bit c);
        bit rdy_exp;
        bit xfer;
        @(negedge clk);
        obs_ov  = get_ov(idx);
        obs_sum = get_sum(idx);
        chk("model out_valid", int'(obs_ov), int'(m_ov[idx]));
        chk("model SUM", int'(obs_sum), m_sum[idx]);
        for (int i = 0; i < 3; i++) begin
            iv_v[i]   = 1'b0;
            clr_v[i]  = 1'b0;
            ordy_v[i] = 1'b0;
        end
        iv_v[idx]   = iv;
        a_v[idx]    = a;
        b_v[idx]    = b;
        ordy_v[idx] = ordy;
        clr_v[idx]  = c;
        #1;
        obs_ir  = get_ir(idx);
        rdy_exp = !c && (m_cnt[idx] < cnt_of(idx));
        chk("model in_ready", int'(obs_ir), int'(rdy_exp));
        if (iv && obs_ir) dut_acc[idx]++;
        xfer = iv && rdy_exp;
        // Model what the coming rising edge does.
        if (c) begin
            m_cnt[idx]  = 0;
            m_part[idx] = 0;
            m_pend[idx] = 1'b0;
            m_ov[idx]   = 1'b0;
        end else begin
            if (m_ov[idx] && ordy) begin
                m_ov[idx]   = 1'b0;
                m_pend[idx] = 1'b0;
                m_cnt[idx]  = 0;
                m_part[idx] = 0;
            end else if (m_pend[idx] && !m_ov[idx]) begin
                m_ov[idx]  = 1'b1;
                m_sum[idx] = m_res[idx];
            end
            if (xfer) begin
                m_part[idx] += int'(a) * int'(b);
                m_cnt[idx]++;
                if (m_cnt[idx] == cnt_of(idx)) begin
                    m_pend[idx] = 1'b1;
                    m_res[idx]  = m_part[idx];
                end
            end
        end
    endtask

    // Assert reset (asynchronously, mid-cycle is fine), check outputs, release at a negedge.
    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("reset in_ready", int'(get_ir(i)), 0);
            chk("reset out_valid", int'(get_ov(i)), 0);
            chk("reset SUM", int'(get_sum(i)), 0);
        end
        iv_v   = '0;
        clr_v  = '0;
        ordy_v = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) chk("in_ready after reset", int'(get_ir(i)), 1);
    endtask

    task automatic feed(int idx, logic [3:0] a, logic [3:0] b, int n, bit gaps);
        int got;
        int budget;
        bit iv;
        got    = 0;
        budget = 300;
        while (got < n && budget > 0) begin
            iv = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
            step(idx, iv, a, b, 1'b1, 1'b0);
            if (iv && obs_ir) got++;
            budget--;
        end
        if (got < n) chk("feed budget", got, n);
    endtask

    task automatic wait_ov(int idx, output logic [11:0] s);
        bit found;
        found = 1'b0;
        s     = '0;
        for (int k = 0; k < 12 && !found; k++) begin
            step(idx, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
            if (obs_ov) begin
                found = 1'b1;
                s     = obs_sum;
            end
        end
        if (!found) chk("out_valid timeout", 0, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        logic [11:0] res;
        int acc_before;
        int n_res;
        bit saw_low;

        tbl[0] = '{a: 16'h1703, b: 16'h1295, sum: 30};
        tbl[1] = '{a: 16'h0000, b: 16'h0000, sum: 0};
        tbl[2] = '{a: 16'hFFFF, b: 16'hFFFF, sum: 900};
        tbl[3] = '{a: 16'h7531, b: 16'h8642, sum: 100};
        tbl[4] = '{a: 16'hF0F8, b: 16'h108F, sum: 255};
        tbl[5] = '{a: 16'h62CA, b: 16'h79DB, sum: 326};

        rst_n  = 1'b1;
        iv_v   = '0;
        clr_v  = '0;
        ordy_v = '0;
        for (int i = 0; i < 3; i++) begin
            a_v[i]     = '0;
            b_v[i]     = '0;
            dut_acc[i] = 0;
        end
        model_reset();
        #2;
        apply_reset();

        // Table vectors on COUNT=4, back-to-back pairs, consumer always ready.
        for (int g = 0; g < 6; g++) begin
            for (int k = 0; k < 4; k++)
                step(0, 1'b1, tbl[g].a[4*k +: 4], tbl[g].b[4*k +: 4], 1'b1, 1'b0);
            step(0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
            chk("tbl out_valid after last accept", int'(obs_ov), 0);
            step(0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
            chk("tbl out_valid one cycle later", int'(obs_ov), 1);
            chk("tbl SUM", int'(obs_sum), tbl[g].sum);
            step(0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
            chk("tbl out_valid single cycle", int'(obs_ov), 0);
            chk("tbl in_ready after drain", int'(obs_ir), 1);
        end

        // COUNT=16, sixteen (15,15) with random gaps, then tempting in_valid while full.
        acc_before = dut_acc[1];
        feed(1, 4'd15, 4'd15, 16, 1'b1);
        for (int k = 0; k < 3; k++) step(1, 1'b1, 4'd15, 4'd15, 1'b0, 1'b0);
        chk("count16 accepts", dut_acc[1] - acc_before, 16);
        wait_ov(1, res);
        chk("count16 SUM", int'(res), 3600);

        // Back-pressure: result held stable while out_ready is low.
        feed(0, 4'd15, 4'd15, 4, 1'b0);
        step(0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        acc_before = dut_acc[0];
        for (int k = 0; k < 5; k++) begin
            step(0, 1'b1, 4'd15, 4'd15, 1'b0, 1'b0);
            chk("hold out_valid", int'(obs_ov), 1);
            chk("hold SUM", int'(obs_sum), 900);
            chk("hold in_ready", int'(obs_ir), 0);
        end
        chk("hold no accepts", dut_acc[0] - acc_before, 0);
        step(0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
        chk("hold still valid at drain", int'(obs_ov), 1);
        step(0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        chk("drained out_valid", int'(obs_ov), 0);
        chk("drained in_ready", int'(obs_ir), 1);

        // Abort after two pairs; aborted products must not leak into the next group.
        feed(0, 4'd3, 4'd3, 1, 1'b0);
        feed(0, 4'd5, 4'd5, 1, 1'b0);
        step(0, 1'b1, 4'd7, 4'd7, 1'b1, 1'b1);
        chk("clr blocks in_ready", int'(obs_ir), 0);
        feed(0, 4'd2, 4'd2, 4, 1'b0);
        wait_ov(0, res);
        chk("after clr SUM", int'(res), 16);

        // Asynchronous reset mid-group after three accepts.
        feed(0, 4'd6, 4'd6, 3, 1'b0);
        @(posedge clk);
        #2;
        apply_reset();
        feed(0, 4'd1, 4'd4, 4, 1'b0);
        wait_ov(0, res);
        chk("after reset SUM", int'(res), 16);

        // COUNT=1: each pair is its own result.
        step(2, 1'b1, 4'd9, 4'd9, 1'b1, 1'b0);
        chk("c1 first accept", int'(obs_ir), 1);
        step(2, 1'b1, 4'd4, 4'd3, 1'b1, 1'b0);
        saw_low = !obs_ir;
        step(2, 1'b1, 4'd4, 4'd3, 1'b1, 1'b0);
        chk("c1 first out_valid", int'(obs_ov), 1);
        chk("c1 first SUM", int'(obs_sum), 81);
        saw_low = saw_low || !obs_ir;
        chk("c1 in_ready dropped", int'(saw_low), 1);
        step(2, 1'b1, 4'd4, 4'd3, 1'b1, 1'b0);
        chk("c1 second accept", int'(obs_ir), 1);
        step(2, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
        chk("c1 in_ready low after accept", int'(obs_ir), 0);
        step(2, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
        chk("c1 second out_valid", int'(obs_ov), 1);
        chk("c1 second SUM", int'(obs_sum), 12);
        step(2, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
        chk("c1 drained", int'(obs_ov), 0);

        // Random traffic with occasional aborts and back-pressure, checked by the model.
        n_res = 0;
        for (int idx = 0; idx < 3; idx++) begin
            for (int k = 0; k < 300; k++) begin
                bit ordy;
                ordy = ($urandom_range(0, 3) != 0);
                step(idx, ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                     4'($urandom_range(0, 15)), ordy, ($urandom_range(0, 49) == 0));
                if (obs_ov && ordy) n_res++;
            end
            for (int k = 0; k < 4; k++) step(idx, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
        end
        chk("random results seen", int'(n_res > 10), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
